ysyx_23060072_regfile: RTL and testbench

RV32E integer register file with an in-flight-write scoreboard. It is the consuming end of the writeback path: it accepts `wb_flag`/`wb_addr`/`wb_data` from the WB stage and serves two bypassed read ports to the ID stage. It also tracks outstanding writes per register and raises a data-hazard stall to ID.

---
 rtl/ysyx_23060072_regfile_pkg.sv | 13 +
 rtl/ysyx_23060072_sb_cnt.sv | 48 ++++
 rtl/ysyx_23060072_regfile.sv | 112 +++++++++++
 tb/tb_ysyx_23060072_regfile.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060072_regfile_pkg.sv
// Shared constants and address rules for the RV32E register file and its scoreboard.
package ysyx_23060072_regfile_pkg;

   localparam int REG_IDX_W = 4;
   localparam int XLEN      = 32;
   localparam int NREG      = 16;

   // Only x1..x15 exist; bit 4 set or x0 means "no register".
   function automatic logic addr_valid(input logic [4:0] addr);
      return (addr[4] == 1'b0) && (addr[3:0] != 4'd0);
   endfunction

endpackage

// File: rtl/ysyx_23060072_sb_cnt.sv
// Saturating up/down counter tracking outstanding writes to one register.
module ysyx_23060072_sb_cnt #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             sat_o,
   output logic             zero_o,
   output logic             underflow_o
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign cnt_o       = cnt_q;
   assign sat_o       = &cnt_q;
   assign zero_o      = (cnt_q == CNT_ZERO);
   assign underflow_o = dec_i & ~inc_i & zero_o;

   // Next count: simultaneous inc and dec cancel; both ends clamp.
   always_comb begin
      cnt_d = cnt_q;
      case ({inc_i, dec_i})
         2'b10: begin
            if (!sat_o) cnt_d = cnt_q + CNT_ONE;
            else        cnt_d = cnt_q;
         end
         2'b01: begin
            if (!zero_o) cnt_d = cnt_q - CNT_ONE;
            else         cnt_d = cnt_q;
         end
         default: cnt_d = cnt_q;
      endcase
   end

   // Counter state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= CNT_ZERO;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ysyx_23060072_regfile.sv
// RV32E register file with write-through bypass and per-register in-flight write
// scoreboard that produces the ID hazard stall.
module ysyx_23060072_regfile
   import ysyx_23060072_regfile_pkg::*;
#(
   parameter int NREG  = 16,
   parameter int CNT_W = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_flag_i,
   input  logic [4:0]      wb_addr_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic            wb_release_i,
   input  logic [4:0]      rs1_addr_i,
   input  logic [4:0]      rs2_addr_i,
   output logic [XLEN-1:0] rs1_data_o,
   output logic [XLEN-1:0] rs2_data_o,
   input  logic            rs1_use_i,
   input  logic            rs2_use_i,
   input  logic            issue_i,
   input  logic [4:0]      issue_rd_i,
   input  logic            issue_wr_i,
   output logic            stall_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [XLEN-1:0]      regs_q [NREG];
   logic [CNT_W-1:0]     cnt_s  [NREG];
   logic [NREG-1:0]      inc_s, dec_s, sat_s, zero_s, uf_s;
   logic                 sb_err_q;

   logic [REG_IDX_W-1:0] wb_idx_s, rs1_idx_s, rs2_idx_s, rd_idx_s;
   logic                 pend1_s, pend2_s, sat_hit_s, reserve_s, release_s;

   assign wb_idx_s  = wb_addr_i[REG_IDX_W-1:0];
   assign rs1_idx_s = rs1_addr_i[REG_IDX_W-1:0];
   assign rs2_idx_s = rs2_addr_i[REG_IDX_W-1:0];
   assign rd_idx_s  = issue_rd_i[REG_IDX_W-1:0];

   // Read ports: invalid addresses read zero, a same-cycle write bypasses the array.
   always_comb begin
      rs1_data_o = {XLEN{1'b0}};
      rs2_data_o = {XLEN{1'b0}};
      if (addr_valid(rs1_addr_i)) begin
         if (wb_flag_i && (wb_addr_i == rs1_addr_i)) rs1_data_o = wb_data_i;
         else                                         rs1_data_o = regs_q[rs1_idx_s];
      end else begin
         rs1_data_o = {XLEN{1'b0}};
      end
      if (addr_valid(rs2_addr_i)) begin
         if (wb_flag_i && (wb_addr_i == rs2_addr_i)) rs2_data_o = wb_data_i;
         else                                         rs2_data_o = regs_q[rs2_idx_s];
      end else begin
         rs2_data_o = {XLEN{1'b0}};
      end
   end

   // Hazard detection; a release this cycle already counts as resolved via the bypass.
   always_comb begin
      pend1_s = addr_valid(rs1_addr_i) && !zero_s[rs1_idx_s] &&
                !((cnt_s[rs1_idx_s] == CNT_ONE) && wb_release_i && (wb_addr_i == rs1_addr_i));
      pend2_s = addr_valid(rs2_addr_i) && !zero_s[rs2_idx_s] &&
                !((cnt_s[rs2_idx_s] == CNT_ONE) && wb_release_i && (wb_addr_i == rs2_addr_i));
      sat_hit_s = issue_wr_i && addr_valid(issue_rd_i) && sat_s[rd_idx_s] &&
                  !(wb_release_i && (wb_addr_i == issue_rd_i));
      stall_o   = issue_i && ((rs1_use_i && pend1_s) || (rs2_use_i && pend2_s) || sat_hit_s);
      reserve_s = issue_i && issue_wr_i && !stall_o && addr_valid(issue_rd_i);
      release_s = wb_release_i && addr_valid(wb_addr_i);
   end

   // Per-register reserve/release strobes.
   always_comb begin
      inc_s = {NREG{1'b0}};
      dec_s = {NREG{1'b0}};
      for (int r = 0; r < NREG; r++) begin
         inc_s[r] = reserve_s && (rd_idx_s == REG_IDX_W'(r));
         dec_s[r] = release_s && (wb_idx_s == REG_IDX_W'(r));
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_cnt
      ysyx_23060072_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk         (clk),
         .rst_n       (rst_n),
         .inc_i       (inc_s[g]),
         .dec_i       (dec_s[g]),
         .cnt_o       (cnt_s[g]),
         .sat_o       (sat_s[g]),
         .zero_o      (zero_s[g]),
         .underflow_o (uf_s[g])
      );
   end

   // Register array write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) regs_q[r] <= {XLEN{1'b0}};
      end else if (wb_flag_i && addr_valid(wb_addr_i)) begin
         regs_q[wb_idx_s] <= wb_data_i;
      end
   end

   // Sticky debug flag for releases without a matching reservation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      sb_err_q <= 1'b0;
      else if (|uf_s)  sb_err_q <= 1'b1;
      else             sb_err_q <= sb_err_q;
   end

endmodule

// File: tb/tb_ysyx_23060072_regfile.sv
// Directed self-checking bench for ysyx_23060072_regfile.
module tb_ysyx_23060072_regfile;

   logic        clk;
   logic        rst_n;
   logic        wb_flag_i;
   logic [4:0]  wb_addr_i;
   logic [31:0] wb_data_i;
   logic        wb_release_i;
   logic [4:0]  rs1_addr_i, rs2_addr_i;
   logic [31:0] rs1_data_o, rs2_data_o;
   logic        rs1_use_i, rs2_use_i;
   logic        issue_i;
   logic [4:0]  issue_rd_i;
   logic        issue_wr_i;
   logic        stall_o;

   int n_checks = 0;
   int n_errors = 0;

   ysyx_23060072_regfile dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wb_flag_i    (wb_flag_i),
      .wb_addr_i    (wb_addr_i),
      .wb_data_i    (wb_data_i),
      .wb_release_i (wb_release_i),
      .rs1_addr_i   (rs1_addr_i),
      .rs2_addr_i   (rs2_addr_i),
      .rs1_data_o   (rs1_data_o),
      .rs2_data_o   (rs2_data_o),
      .rs1_use_i    (rs1_use_i),
      .rs2_use_i    (rs2_use_i),
      .issue_i      (issue_i),
      .issue_rd_i   (issue_rd_i),
      .issue_wr_i   (issue_wr_i),
      .stall_o      (stall_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change 1 time unit after it, checks 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_flag_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'd0; wb_release_i = 1'b0;
      rs1_use_i = 1'b0; rs2_use_i = 1'b0;
      issue_i = 1'b0; issue_rd_i = 5'd0; issue_wr_i = 1'b0;
   endtask

   task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
      wb_flag_i = 1'b1; wb_addr_i = a; wb_data_i = d;
      tick();
      idle();
   endtask

   initial begin
      idle();
      rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;

      // Reset state
      rs1_addr_i = 5'd5; #1;
      check_eq("rst_rd_x5", rs1_data_o, 32'd0);
      check_eq("rst_stall", {31'd0, stall_o}, 32'd0);
      check_eq("rst_cnt5", {30'd0, dut.cnt_s[5]}, 32'd0);
      check_eq("rst_sberr", {31'd0, dut.sb_err_q}, 32'd0);

      // Write then read back
      wb_write(5'd5, 32'hDEADBEEF); #1;
      check_eq("rd_x5", rs1_data_o, 32'hDEADBEEF);

      // x0 and bit4 addresses are not writable and do not alias x1
      wb_write(5'd1, 32'h11111111);
      wb_write(5'd0, 32'h00001234);
      wb_write(5'd17, 32'h00000055);
      rs1_addr_i = 5'd0; rs2_addr_i = 5'd17; #1;
      check_eq("rd_x0", rs1_data_o, 32'd0);
      check_eq("rd_x17", rs2_data_o, 32'd0);
      rs1_addr_i = 5'd1; #1;
      check_eq("x1_kept", rs1_data_o, 32'h11111111);
      check_eq("cnt1_idle", {30'd0, dut.cnt_s[1]}, 32'd0);

      // Same-cycle write-through bypass
      wb_flag_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'hA5A5A5A5; rs2_addr_i = 5'd7; #1;
      check_eq("bypass_rs2", rs2_data_o, 32'hA5A5A5A5);
      tick(); idle();

      // RAW hazard on x3
      issue_i = 1'b1; issue_wr_i = 1'b1; issue_rd_i = 5'd3; #1;
      check_eq("issue_rd3_nostall", {31'd0, stall_o}, 32'd0);
      tick(); idle();
      issue_i = 1'b1; rs1_addr_i = 5'd3; rs1_use_i = 1'b1; #1;
      check_eq("raw_stall", {31'd0, stall_o}, 32'd1);
      check_eq("cnt3_one", {30'd0, dut.cnt_s[3]}, 32'd1);
      rs1_use_i = 1'b0; #1;
      check_eq("raw_nouse", {31'd0, stall_o}, 32'd0);
      rs1_use_i = 1'b1;
      tick();
      check_eq("raw_hold", {31'd0, stall_o}, 32'd1);
      wb_flag_i = 1'b1; wb_release_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h42; #1;
      check_eq("raw_release_nostall", {31'd0, stall_o}, 32'd0);
      check_eq("raw_release_data", rs1_data_o, 32'h42);
      tick(); idle(); #1;
      check_eq("cnt3_zero", {30'd0, dut.cnt_s[3]}, 32'd0);
      check_eq("x3_stored", rs1_data_o, 32'h42);

      // Saturation on x9
      for (int i = 0; i < 3; i++) begin
         issue_i = 1'b1; issue_wr_i = 1'b1; issue_rd_i = 5'd9; #1;
         check_eq("sat_fill_nostall", {31'd0, stall_o}, 32'd0);
         tick();
      end
      idle(); #1;
      check_eq("cnt9_three", {30'd0, dut.cnt_s[9]}, 32'd3);
      issue_i = 1'b1; issue_wr_i = 1'b1; issue_rd_i = 5'd9; #1;
      check_eq("sat_stall", {31'd0, stall_o}, 32'd1);
      tick(); #1;
      check_eq("cnt9_held", {30'd0, dut.cnt_s[9]}, 32'd3);
      wb_release_i = 1'b1; wb_addr_i = 5'd9; #1;
      check_eq("sat_rel_nostall", {31'd0, stall_o}, 32'd0);
      tick(); idle(); #1;
      check_eq("cnt9_same", {30'd0, dut.cnt_s[9]}, 32'd3);

      // Release x9 while reserving x10: both apply
      issue_i = 1'b1; issue_wr_i = 1'b1; issue_rd_i = 5'd10;
      wb_release_i = 1'b1; wb_addr_i = 5'd9;
      tick(); idle(); #1;
      check_eq("cnt9_two", {30'd0, dut.cnt_s[9]}, 32'd2);
      check_eq("cnt10_one", {30'd0, dut.cnt_s[10]}, 32'd1);
      issue_i = 1'b1; rs2_addr_i = 5'd10; rs2_use_i = 1'b1; #1;
      check_eq("rs2_stall", {31'd0, stall_o}, 32'd1);
      issue_i = 1'b0; #1;
      check_eq("no_issue_nostall", {31'd0, stall_o}, 32'd0);
      idle();

      // Underflow on x4 with a plain write alongside
      wb_flag_i = 1'b1; wb_release_i = 1'b1; wb_addr_i = 5'd4; wb_data_i = 32'h77;
      tick(); idle();
      rs1_addr_i = 5'd4; #1;
      check_eq("cnt4_zero", {30'd0, dut.cnt_s[4]}, 32'd0);
      check_eq("sberr_set", {31'd0, dut.sb_err_q}, 32'd1);
      check_eq("x4_written", rs1_data_o, 32'h77);

      // Asynchronous reset mid-stream
      #1 rst_n = 1'b0; #1;
      check_eq("mrst_cnt9", {30'd0, dut.cnt_s[9]}, 32'd0);
      check_eq("mrst_cnt10", {30'd0, dut.cnt_s[10]}, 32'd0);
      check_eq("mrst_sberr", {31'd0, dut.sb_err_q}, 32'd0);
      check_eq("mrst_x4", rs1_data_o, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
